// File: rtl/stopwatch_ctrl_if.sv
// Board/counter-side signal bundle for the stopwatch sequencer.
// All outputs are single-cycle strobes or levels with no backpressure:
// a strobe is consumed in the cycle it is high, and there is no ready.
interface stopwatch_ctrl_if;
    logic       btn_pause;
    logic       btn_clear;
    logic       sw_adj;
    logic       sw_sel;
    logic       count_en;
    logic       count_clr;
    logic       adj_en;
    logic       adj_sel;
    logic       blink;
    logic [1:0] state;

    // Sequencer side: reads raw board I/O, drives counter/display controls.
    modport master (
        input  btn_pause, btn_clear, sw_adj, sw_sel,
        output count_en, count_clr, adj_en, adj_sel, blink, state
    );

    // Board/counter side: drives raw I/O, consumes the controls.
    modport slave (
        output btn_pause, btn_clear, sw_adj, sw_sel,
        input  count_en, count_clr, adj_en, adj_sel, blink, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear/adjust sequencer: synchronises and debounces board
// inputs, runs the IDLE/RUN/PAUSE/ADJUST FSM and generates the 1 Hz count
// enable, adjust increment pulses and display blink gate.
module stopwatch_ctrl #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 1,
    parameter int ADJ_HZ    = 2,
    parameter int BLINK_HZ  = 2,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             reset,
    stopwatch_ctrl_if.master sw_if
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSE  = 2'b10,
        ST_ADJUST = 2'b11
    } state_e;

    localparam int TICK_DIV  = CLK_HZ / TICK_HZ;
    localparam int ADJ_DIV   = CLK_HZ / ADJ_HZ;
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int TICK_W    = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int ADJ_W     = (ADJ_DIV   > 1) ? $clog2(ADJ_DIV)   : 1;
    localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int DB_W      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    localparam logic [TICK_W-1:0]  TICK_TERM  = TICK_W'(TICK_DIV - 1);
    localparam logic [ADJ_W-1:0]   ADJ_TERM   = ADJ_W'(ADJ_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_TERM = BLINK_W'(BLINK_DIV - 1);
    localparam logic [DB_W-1:0]    DB_TERM    = DB_W'(DB_CYCLES - 1);

    // Bit order of the synchronised input vector: {sel, adj, clear, pause}.
    logic [3:0] raw_in;
    logic [3:0] sync1_q, sync2_q;

    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];
    logic [1:0]      db_lvl_q, db_lvl_d;
    logic [1:0]      ev_q, ev_d;

    state_e              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [ADJ_W-1:0]    adj_div_q, adj_div_d;
    logic [BLINK_W-1:0]  blink_div_q, blink_div_d;
    logic                blink_q, blink_d;
    logic                count_clr_q;

    logic pause_ev, clear_ev, adj_lvl, sel_lvl;
    logic count_en, adj_en, stay_adjust;

    assign raw_in   = {sw_if.sw_sel, sw_if.sw_adj, sw_if.btn_clear, sw_if.btn_pause};
    assign pause_ev = ev_q[0];
    assign clear_ev = ev_q[1];
    assign adj_lvl  = sync2_q[2];
    assign sel_lvl  = sync2_q[3];

    // Debounce: accept a new button level after DB_CYCLES differing samples;
    // a press event fires once on the accepted 0->1 change.
    always_comb begin
        db_lvl_d = db_lvl_q;
        ev_d     = 2'b00;
        for (int b = 0; b < 2; b++) begin
            db_cnt_d[b] = '0;
            if (sync2_q[b] != db_lvl_q[b]) begin
                if (db_cnt_q[b] == DB_TERM) begin
                    db_lvl_d[b] = sync2_q[b];
                    ev_d[b]     = sync2_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
                end
            end
        end
    end

    // Next-state logic; clear overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_PAUSE: begin
                if (adj_lvl)       state_d = ST_ADJUST;
                else if (pause_ev) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (pause_ev) state_d = ST_PAUSE;
            end
            ST_ADJUST: begin
                if (!adj_lvl) state_d = ST_PAUSE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear_ev) state_d = ST_IDLE;
    end

    // Dividers and blink; adjust/blink dividers only advance while staying in ADJUST.
    always_comb begin
        count_en    = (state_q == ST_RUN) && (tick_q == TICK_TERM);
        adj_en      = (state_q == ST_ADJUST) && (adj_div_q == ADJ_TERM);
        stay_adjust = (state_q == ST_ADJUST) && (state_d == ST_ADJUST);

        tick_d = tick_q;
        if (clear_ev || (state_q == ST_ADJUST && state_d == ST_PAUSE)) begin
            tick_d = '0;
        end else if (state_q == ST_RUN) begin
            tick_d = count_en ? '0 : tick_q + TICK_W'(1);
        end

        adj_div_d   = '0;
        blink_div_d = '0;
        blink_d     = 1'b1;
        if (stay_adjust) begin
            adj_div_d = adj_en ? '0 : adj_div_q + ADJ_W'(1);
            if (blink_div_q == BLINK_TERM) begin
                blink_d = ~blink_q;
            end else begin
                blink_d     = blink_q;
                blink_div_d = blink_div_q + BLINK_W'(1);
            end
        end
    end

    // All state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_cnt_q    <= '{default: '0};
            db_lvl_q    <= '0;
            ev_q        <= '0;
            state_q     <= ST_IDLE;
            tick_q      <= '0;
            adj_div_q   <= '0;
            blink_div_q <= '0;
            blink_q     <= 1'b1;
            count_clr_q <= 1'b0;
        end else begin
            sync1_q     <= raw_in;
            sync2_q     <= sync1_q;
            db_cnt_q    <= db_cnt_d;
            db_lvl_q    <= db_lvl_d;
            ev_q        <= ev_d;
            state_q     <= state_d;
            tick_q      <= tick_d;
            adj_div_q   <= adj_div_d;
            blink_div_q <= blink_div_d;
            blink_q     <= blink_d;
            count_clr_q <= clear_ev;
        end
    end

    assign sw_if.count_en  = count_en;
    assign sw_if.count_clr = count_clr_q;
    assign sw_if.adj_en    = adj_en;
    assign sw_if.adj_sel   = sel_lvl;
    assign sw_if.blink     = blink_q;
    assign sw_if.state     = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with small clock/divider constants.
module tb_stopwatch_ctrl;
    localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSE = 2'b10, S_ADJ = 2'b11;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    stopwatch_ctrl_if sw_if();

    stopwatch_ctrl #(
        .CLK_HZ(20), .TICK_HZ(1), .ADJ_HZ(2), .BLINK_HZ(2), .DB_CYCLES(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sw_if (sw_if)
    );

    always #5 clk = ~clk;

    // One phase: hold inputs for a number of cycles, then compare event
    // counts and the 1-based sample index of first/last events.
    typedef struct {
        logic       pause, clear, adj, sel, bounce;
        int         cycles;
        logic [1:0] exp_state;
        int         exp_trans, exp_first_trans;
        int         exp_cen, exp_first_cen, exp_last_cen;
        int         exp_aen, exp_first_aen, exp_last_aen;
        int         exp_clr, exp_first_clr;
        int         exp_blink_chg;
    } phase_t;

    phase_t phases [17];

    function automatic phase_t mk(
        input logic pause, clear, adj, sel, bounce, input int cycles, input logic [1:0] st,
        input int tr, ftr, cen, fcen, lcen, aen, faen, laen, clr, fclr, bchg);
        phase_t p;
        p.pause = pause; p.clear = clear; p.adj = adj; p.sel = sel; p.bounce = bounce;
        p.cycles = cycles; p.exp_state = st;
        p.exp_trans = tr; p.exp_first_trans = ftr;
        p.exp_cen = cen; p.exp_first_cen = fcen; p.exp_last_cen = lcen;
        p.exp_aen = aen; p.exp_first_aen = faen; p.exp_last_aen = laen;
        p.exp_clr = clr; p.exp_first_clr = fclr; p.exp_blink_chg = bchg;
        return p;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_phase(input int idx, input phase_t p);
        int trans = 0, ftrans = 0, cen = 0, fcen = 0, lcen = 0;
        int aen = 0, faen = 0, laen = 0, clr = 0, fclr = 0, bchg = 0;
        logic [1:0] prev_state;
        logic       prev_blink;
        string      tag;
        tag = $sformatf("p%0d", idx);
        prev_state = sw_if.state;
        prev_blink = sw_if.blink;
        for (int k = 0; k < p.cycles; k++) begin
            sw_if.btn_pause = p.bounce ? ((k < 30) ? (k[1] == 1'b0) : 1'b1) : p.pause;
            sw_if.btn_clear = p.clear;
            sw_if.sw_adj    = p.adj;
            sw_if.sw_sel    = p.sel;
            cycle();
            check({tag, ".excl"}, int'(sw_if.count_en) + int'(sw_if.adj_en) + int'(sw_if.count_clr) <= 1, 1);
            if (sw_if.state != S_ADJ) check({tag, ".blink_hi"}, int'(sw_if.blink), 1);
            if (sw_if.adj_en) check({tag, ".adj_sel"}, int'(sw_if.adj_sel), int'(p.sel));
            if (sw_if.state != prev_state) begin trans++; if (ftrans == 0) ftrans = k + 1; end
            if (sw_if.count_en)  begin cen++; if (fcen == 0) fcen = k + 1; lcen = k + 1; end
            if (sw_if.adj_en)    begin aen++; if (faen == 0) faen = k + 1; laen = k + 1; end
            if (sw_if.count_clr) begin clr++; if (fclr == 0) fclr = k + 1; end
            if (sw_if.blink != prev_blink) bchg++;
            prev_state = sw_if.state;
            prev_blink = sw_if.blink;
        end
        check({tag, ".state"},       int'(sw_if.state), int'(p.exp_state));
        check({tag, ".trans"},       trans, p.exp_trans);
        check({tag, ".first_trans"}, ftrans, p.exp_first_trans);
        check({tag, ".cen"},         cen, p.exp_cen);
        check({tag, ".first_cen"},   fcen, p.exp_first_cen);
        check({tag, ".last_cen"},    lcen, p.exp_last_cen);
        check({tag, ".aen"},         aen, p.exp_aen);
        check({tag, ".first_aen"},   faen, p.exp_first_aen);
        check({tag, ".last_aen"},    laen, p.exp_last_aen);
        check({tag, ".clr"},         clr, p.exp_clr);
        check({tag, ".first_clr"},   fclr, p.exp_first_clr);
        check({tag, ".blink_chg"},   bchg, p.exp_blink_chg);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".state"},     int'(sw_if.state), int'(S_IDLE));
        check({tag, ".count_en"},  int'(sw_if.count_en), 0);
        check({tag, ".count_clr"}, int'(sw_if.count_clr), 0);
        check({tag, ".adj_en"},    int'(sw_if.adj_en), 0);
        check({tag, ".adj_sel"},   int'(sw_if.adj_sel), 0);
        check({tag, ".blink"},     int'(sw_if.blink), 1);
    endtask

    initial begin
        int not_idle;
        //              pa cl ad se bo cyc state    tr ftr cen fc  lc  aen fa la clr fcl bchg
        phases[0]  = mk(0, 0, 0, 0, 0, 5,  S_IDLE,  0, 0,  0, 0,  0,  0, 0, 0,  0, 0, 0); // idle
        phases[1]  = mk(1, 0, 0, 0, 0, 10, S_RUN,   1, 7,  0, 0,  0,  0, 0, 0,  0, 0, 0); // start
        phases[2]  = mk(0, 0, 0, 0, 0, 42, S_RUN,   0, 0,  2, 16, 36, 0, 0, 0,  0, 0, 0); // counting
        phases[3]  = mk(1, 0, 0, 0, 0, 10, S_PAUSE, 1, 7,  0, 0,  0,  0, 0, 0,  0, 0, 0); // pause at div 12
        phases[4]  = mk(0, 0, 0, 0, 0, 10, S_PAUSE, 0, 0,  0, 0,  0,  0, 0, 0,  0, 0, 0); // held
        phases[5]  = mk(1, 0, 0, 0, 0, 30, S_RUN,   1, 7,  1, 14, 14, 0, 0, 0,  0, 0, 0); // resume: 8th RUN cycle
        phases[6]  = mk(0, 0, 0, 0, 0, 12, S_RUN,   0, 0,  1, 4,  4,  0, 0, 0,  0, 0, 0);
        phases[7]  = mk(0, 0, 0, 0, 1, 40, S_PAUSE, 1, 35, 2, 12, 32, 0, 0, 0,  0, 0, 0); // bounce
        phases[8]  = mk(0, 0, 0, 0, 0, 10, S_PAUSE, 0, 0,  0, 0,  0,  0, 0, 0,  0, 0, 0);
        phases[9]  = mk(0, 0, 1, 1, 0, 40, S_ADJ,   1, 3,  0, 0,  0,  3, 12, 32, 0, 0, 7); // adjust
        phases[10] = mk(0, 0, 0, 1, 0, 10, S_PAUSE, 1, 3,  0, 0,  0,  1, 2, 2,  0, 0, 1); // exit adjust
        phases[11] = mk(0, 0, 0, 0, 0, 5,  S_PAUSE, 0, 0,  0, 0,  0,  0, 0, 0,  0, 0, 0);
        phases[12] = mk(1, 0, 0, 0, 0, 30, S_RUN,   1, 7,  1, 26, 26, 0, 0, 0,  0, 0, 0); // divider was zeroed
        phases[13] = mk(0, 0, 0, 0, 0, 8,  S_RUN,   0, 0,  0, 0,  0,  0, 0, 0,  0, 0, 0);
        phases[14] = mk(1, 1, 0, 0, 0, 10, S_IDLE,  1, 7,  0, 0,  0,  0, 0, 0,  1, 7, 0); // clear beats pause
        phases[15] = mk(0, 0, 0, 0, 0, 10, S_IDLE,  0, 0,  0, 0,  0,  0, 0, 0,  0, 0, 0);
        phases[16] = mk(0, 1, 1, 0, 0, 12, S_ADJ,   3, 3,  0, 0,  0,  0, 0, 0,  1, 7, 0); // clear in adjust

        sw_if.btn_pause = 1'b0;
        sw_if.btn_clear = 1'b0;
        sw_if.sw_adj    = 1'b0;
        sw_if.sw_sel    = 1'b0;
        reset = 1'b1;
        repeat (3) cycle();
        check_reset_outputs("por");
        reset = 1'b0;

        for (int i = 0; i < 17; i++) run_phase(i, phases[i]);

        // One-cycle reset while in ADJUST mid-period, switch released.
        reset           = 1'b1;
        sw_if.btn_clear = 1'b0;
        sw_if.sw_adj    = 1'b0;
        cycle();
        check_reset_outputs("midrst");
        reset = 1'b0;
        not_idle = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (sw_if.state != S_IDLE || sw_if.blink != 1'b1) not_idle++;
        end
        check("midrst.stay_idle", not_idle, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
